// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction constants, PC source codes
// and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches words over imem req/ack and
// loads IF/ID. Branch/jump redirects take effect after the delay slot.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic [1:0]  if_pc_source,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instruction,
  output logic [31:0] IF_ID_next_i_addr
);

  // Memory handshake: imem_req stays high in FETCH until a cycle with
  // imem_ack = 1 completes the access; imem_addr is the PC and only moves on
  // delivery into IF/ID, so it is stable from request to ack.

  if_state_t   state, state_next;
  logic [31:0] pc;
  logic [31:0] ibuf;
  logic        redir_valid;
  logic [31:0] redir_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;

  logic        take_branch;
  logic        take_jump;
  logic        deliver;
  logic        bubble;
  logic        buffer_word;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] redir_target;
  logic [31:0] deliver_word;

  assign pc_plus4    = pc + 32'd4;
  assign take_branch = !hazard && (if_pc_source == PC_SRC_BRANCH);
  assign take_jump   = !hazard && (if_pc_source == PC_SRC_JUMP);
  assign redir_target = take_branch ? branch_addr : jump_addr;

  // Next-state and datapath enables; imem_ack is only honoured in FETCH.
  always_comb begin
    state_next   = state;
    deliver      = 1'b0;
    bubble       = 1'b0;
    buffer_word  = 1'b0;
    deliver_word = imem_rdata;
    unique case (state)
      FETCH: begin
        if (imem_ack && !hazard) begin
          deliver = 1'b1;
        end else if (imem_ack && hazard) begin
          buffer_word = 1'b1;
          state_next  = HOLD;
        end else if (!hazard) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        deliver_word = ibuf;
        if (!hazard) begin
          deliver    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // A pending redirect outranks a live one: it belongs to an older branch.
  always_comb begin
    if (redir_valid)      next_pc = redir_addr;
    else if (take_branch) next_pc = branch_addr;
    else if (take_jump)   next_pc = jump_addr;
    else                  next_pc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ibuf        <= 32'h0;
      redir_valid <= 1'b0;
      redir_addr  <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= 32'h0;
    end else begin
      if (buffer_word) begin
        ibuf <= imem_rdata;
      end
      if (deliver) begin
        pc          <= next_pc;
        redir_valid <= 1'b0;
        if_id_instr <= deliver_word;
        if_id_npc   <= pc_plus4;
      end else begin
        if (take_branch || take_jump) begin
          redir_valid <= 1'b1;
          redir_addr  <= redir_target;
        end
        if (bubble) begin
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

  assign imem_req          = !rst && (state == FETCH);
  assign imem_addr         = pc;
  assign IF_ID_instruction = if_id_instr;
  assign IF_ID_next_i_addr = if_id_npc;

endmodule
